// File: rtl/fpu_queue_pkg.sv
// Shared definitions for the FPU decoder -> NEU instruction queue: descriptor layout,
// default sizes and the descriptor pack/unpack helpers.
package fpu_queue_pkg;

  localparam int unsigned OPC_LSB  = 0;
  localparam int unsigned OPC_W    = 8;
  localparam int unsigned IDX_LSB  = 8;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned MEM_LSB  = 11;
  localparam int unsigned SIZE_LSB = 12;
  localparam int unsigned SIZE_W   = 2;
  localparam int unsigned INT_LSB  = 14;
  localparam int unsigned BCD_LSB  = 15;
  localparam int unsigned META_W   = 16;

  localparam int unsigned DEFAULT_DEPTH  = 3;
  localparam int unsigned DEFAULT_DATA_W = 80;

  typedef struct packed {
    logic              is_bcd;
    logic              is_int;
    logic [SIZE_W-1:0] op_size;
    logic              has_mem;
    logic [IDX_W-1:0]  stack_idx;
    logic [OPC_W-1:0]  opcode;
  } fpu_desc_t;

  function automatic logic [META_W-1:0] pack_desc(fpu_desc_t d);
    logic [META_W-1:0] m;
    m = '0;
    m[OPC_LSB +: OPC_W]   = d.opcode;
    m[IDX_LSB +: IDX_W]   = d.stack_idx;
    m[MEM_LSB]            = d.has_mem;
    m[SIZE_LSB +: SIZE_W] = d.op_size;
    m[INT_LSB]            = d.is_int;
    m[BCD_LSB]            = d.is_bcd;
    return m;
  endfunction

  function automatic fpu_desc_t unpack_desc(logic [META_W-1:0] m);
    fpu_desc_t d;
    d.opcode    = m[OPC_LSB +: OPC_W];
    d.stack_idx = m[IDX_LSB +: IDX_W];
    d.has_mem   = m[MEM_LSB];
    d.op_size   = m[SIZE_LSB +: SIZE_W];
    d.is_int    = m[INT_LSB];
    d.is_bcd    = m[BCD_LSB];
    return d;
  endfunction

  // Modulo-depth successor; depth need not be a power of two.
  function automatic int unsigned next_idx(int unsigned idx, int unsigned depth);
    return (idx == depth - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fpu_queue_ptr.sv
// Modulo-DEPTH pointer register with load (priority) and increment.
module fpu_queue_ptr
  import fpu_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  input  logic             load_i,
  input  logic [PTR_W-1:0] load_val_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (inc_i) begin
      ptr_d = PTR_W'(next_idx(32'(ptr_q), DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fpu_instruction_fifo.sv
// Instruction/operand FIFO between FPU decoder and NEU with head+1 peek, almost-full,
// head-preserving flush and sticky overflow.
module fpu_instruction_fifo
  import fpu_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned META_W   = fpu_queue_pkg::META_W,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enq_valid_i,
  input  logic [META_W-1:0] enq_meta_i,
  input  logic [DATA_W-1:0] enq_data_i,
  output logic              enq_ready_o,
  output logic              deq_valid_o,
  input  logic              deq_ready_i,
  output logic [META_W-1:0] deq_meta_o,
  output logic [DATA_W-1:0] deq_data_o,
  output logic              peek_valid_o,
  output logic [META_W-1:0] peek_meta_o,
  input  logic              flush_i,
  input  logic              flush_keep_head_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              almost_full_o,
  output logic              err_overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = META_W + DATA_W;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q;
  logic [PTR_W-1:0] rd_ptr, rd_next, wr_ptr, wr_load_val;
  logic             flush_any, enq_fire, deq_fire, wr_load;

  assign flush_any   = flush_i | flush_keep_head_i;
  assign enq_ready_o = (32'(count_q) < DEPTH) && !flush_any;
  assign deq_valid_o = (count_q != '0) && !flush_any;
  assign enq_fire    = enq_valid_i && enq_ready_o;
  assign deq_fire    = deq_valid_o && deq_ready_i;
  assign rd_next     = PTR_W'(next_idx(32'(rd_ptr), DEPTH));

  // Keep-head flush rewinds wr to just behind the head; a full flush wins.
  assign wr_load     = flush_i || (flush_keep_head_i && (count_q != '0));
  assign wr_load_val = flush_i ? '0 : rd_next;

  fpu_queue_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .inc_i      (deq_fire),
    .load_i     (flush_i),
    .load_val_i ('0),
    .ptr_o      (rd_ptr)
  );

  fpu_queue_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .inc_i      (enq_fire),
    .load_i     (wr_load),
    .load_val_i (wr_load_val),
    .ptr_o      (wr_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (flush_keep_head_i) begin
      if (count_q != '0) count_d = CNT_W'(1);
    end else if (enq_fire && !deq_fire) begin
      count_d = count_q + CNT_W'(1);
    end else if (!enq_fire && deq_fire) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (enq_valid_i && !enq_ready_o && !flush_any) err_q <= 1'b1;
      if (enq_fire) mem_q[wr_ptr] <= {enq_meta_i, enq_data_i};
    end
  end

  assign deq_meta_o     = deq_valid_o ? mem_q[rd_ptr][ENT_W-1 -: META_W] : '0;
  assign deq_data_o     = deq_valid_o ? mem_q[rd_ptr][DATA_W-1:0] : '0;
  assign peek_valid_o   = 32'(count_q) >= 2;
  assign peek_meta_o    = peek_valid_o ? mem_q[rd_next][ENT_W-1 -: META_W] : '0;
  assign count_o        = count_q;
  assign almost_full_o  = 32'(count_q) >= AF_LEVEL;
  assign err_overflow_o = err_q;

endmodule

// File: tb/tb_fpu_instruction_fifo.sv
// Bench for fpu_instruction_fifo: directed vector table, hand sequences (wrap, almost-full,
// mid-fill reset) and randomized traffic against a queue-based reference model.
module tb_fpu_instruction_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=3 instance
  logic        a_rst, a_ev, a_rdy, a_dv, a_dr, a_pv, a_fl, a_fkh, a_af, a_ovf;
  logic [15:0] a_em, a_dm, a_pm;
  logic [79:0] a_ed, a_dd;
  logic [1:0]  a_cnt;

  // DEPTH=5, AF_LEVEL=4 instance
  logic        b_rst, b_ev, b_rdy, b_dv, b_dr, b_pv, b_fl, b_fkh, b_af, b_ovf;
  logic [15:0] b_em, b_dm, b_pm;
  logic [79:0] b_ed, b_dd;
  logic [2:0]  b_cnt;

  fpu_instruction_fifo #(.DEPTH(3), .DATA_W(80), .META_W(16)) u_dut (
    .clk_i(clk), .reset_i(a_rst), .enq_valid_i(a_ev), .enq_meta_i(a_em), .enq_data_i(a_ed),
    .enq_ready_o(a_rdy), .deq_valid_o(a_dv), .deq_ready_i(a_dr), .deq_meta_o(a_dm),
    .deq_data_o(a_dd), .peek_valid_o(a_pv), .peek_meta_o(a_pm), .flush_i(a_fl),
    .flush_keep_head_i(a_fkh), .count_o(a_cnt), .almost_full_o(a_af), .err_overflow_o(a_ovf)
  );

  fpu_instruction_fifo #(.DEPTH(5), .DATA_W(80), .META_W(16), .AF_LEVEL(4)) u_dut5 (
    .clk_i(clk), .reset_i(b_rst), .enq_valid_i(b_ev), .enq_meta_i(b_em), .enq_data_i(b_ed),
    .enq_ready_o(b_rdy), .deq_valid_o(b_dv), .deq_ready_i(b_dr), .deq_meta_o(b_dm),
    .deq_data_o(b_dd), .peek_valid_o(b_pv), .peek_meta_o(b_pm), .flush_i(b_fl),
    .flush_keep_head_i(b_fkh), .count_o(b_cnt), .almost_full_o(b_af), .err_overflow_o(b_ovf)
  );

  int checks = 0;
  int failures = 0;

  function automatic logic [79:0] data_of(logic [15:0] m);
    return {m, ~m, m, ~m, m};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit rst; bit ev; logic [15:0] m; bit dr; bit fl; bit fkh;
    int cnt; bit rdy; bit dv; logic [15:0] hd; bit pv; logic [15:0] pk; bit ovf;
  } vec_t;
  vec_t tbl[$];

  task automatic add(bit i_rst, bit i_ev, logic [15:0] i_m, bit i_dr, bit i_fl, bit i_fkh,
                     int x_cnt, bit x_rdy, bit x_dv, logic [15:0] x_hd, bit x_pv,
                     logic [15:0] x_pk, bit x_ovf);
    vec_t v;
    v.rst = i_rst; v.ev = i_ev; v.m = i_m; v.dr = i_dr; v.fl = i_fl; v.fkh = i_fkh;
    v.cnt = x_cnt; v.rdy = x_rdy; v.dv = x_dv; v.hd = x_hd; v.pv = x_pv; v.pk = x_pk;
    v.ovf = x_ovf;
    tbl.push_back(v);
  endtask

  task automatic a_idle();
    a_rst = 0; a_ev = 0; a_em = '0; a_ed = '0; a_dr = 0; a_fl = 0; a_fkh = 0;
  endtask

  // Reference model: an ordered list of entries plus the sticky overflow bit.
  typedef struct { logic [15:0] m; logic [79:0] d; } ent_t;
  ent_t mq[$];
  bit   m_ovf;

  initial begin
    logic [15:0] hd;
    a_idle();
    a_rst = 1;
    b_rst = 1; b_ev = 0; b_em = '0; b_ed = '0; b_dr = 0; b_fl = 0; b_fkh = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_rst = 0; b_rst = 0;
    #1;
    chk("reset count", a_cnt, 0);
    chk("reset enq_ready", a_rdy, 1);
    chk("reset deq_valid", a_dv, 0);
    chk("reset deq_meta", a_dm, 0);
    chk("reset deq_data", a_dd, 0);
    chk("reset peek_valid", a_pv, 0);
    chk("reset peek_meta", a_pm, 0);
    chk("reset almost_full", a_af, 0);
    chk("reset err_overflow", a_ovf, 0);

    //   rst ev meta    dr fl fkh | cnt rdy dv head    pv peek    ovf
    add(0, 1, 16'h11, 0, 0, 0,  1, 1, 1, 16'h11, 0, 16'h00, 0);
    add(0, 1, 16'h22, 0, 0, 0,  2, 1, 1, 16'h11, 1, 16'h22, 0);
    add(0, 1, 16'h33, 0, 0, 0,  3, 0, 1, 16'h11, 1, 16'h22, 0);
    add(0, 1, 16'h44, 0, 0, 0,  3, 0, 1, 16'h11, 1, 16'h22, 1);
    add(0, 0, 16'h00, 1, 0, 0,  2, 1, 1, 16'h22, 1, 16'h33, 1);
    add(0, 0, 16'h00, 1, 0, 0,  1, 1, 1, 16'h33, 0, 16'h00, 1);
    add(0, 0, 16'h00, 1, 0, 0,  0, 1, 0, 16'h00, 0, 16'h00, 1);
    add(0, 1, 16'hA1, 0, 0, 0,  1, 1, 1, 16'hA1, 0, 16'h00, 1);
    add(0, 1, 16'hB2, 0, 0, 0,  2, 1, 1, 16'hA1, 1, 16'hB2, 1);
    add(0, 0, 16'h00, 1, 0, 0,  1, 1, 1, 16'hB2, 0, 16'h00, 1);
    add(0, 0, 16'h00, 1, 0, 0,  0, 1, 0, 16'h00, 0, 16'h00, 1);
    add(1, 1, 16'h99, 0, 0, 0,  0, 1, 0, 16'h00, 0, 16'h00, 0);
    add(0, 1, 16'h11, 0, 0, 0,  1, 1, 1, 16'h11, 0, 16'h00, 0);
    add(0, 1, 16'h22, 0, 0, 0,  2, 1, 1, 16'h11, 1, 16'h22, 0);
    add(0, 1, 16'h33, 0, 0, 0,  3, 0, 1, 16'h11, 1, 16'h22, 0);
    add(0, 1, 16'h77, 1, 0, 1,  1, 1, 1, 16'h11, 0, 16'h00, 0);
    add(0, 1, 16'h55, 0, 0, 0,  2, 1, 1, 16'h11, 1, 16'h55, 0);
    add(0, 1, 16'h66, 1, 1, 0,  0, 1, 0, 16'h00, 0, 16'h00, 0);
    add(0, 1, 16'h81, 0, 0, 0,  1, 1, 1, 16'h81, 0, 16'h00, 0);
    add(0, 1, 16'h82, 0, 0, 0,  2, 1, 1, 16'h81, 1, 16'h82, 0);
    add(0, 1, 16'h83, 0, 0, 0,  3, 0, 1, 16'h81, 1, 16'h82, 0);
    add(0, 1, 16'h84, 1, 0, 0,  2, 1, 1, 16'h82, 1, 16'h83, 1);
    add(0, 1, 16'h85, 1, 0, 0,  2, 1, 1, 16'h83, 1, 16'h85, 1);

    foreach (tbl[i]) begin
      @(negedge clk);
      a_rst = tbl[i].rst; a_ev = tbl[i].ev; a_em = tbl[i].m; a_ed = data_of(tbl[i].m);
      a_dr = tbl[i].dr; a_fl = tbl[i].fl; a_fkh = tbl[i].fkh;
      @(posedge clk);
      #1;
      a_idle();
      #1;
      chk($sformatf("vec%0d count", i), a_cnt, tbl[i].cnt);
      chk($sformatf("vec%0d enq_ready", i), a_rdy, tbl[i].rdy);
      chk($sformatf("vec%0d deq_valid", i), a_dv, tbl[i].dv);
      chk($sformatf("vec%0d deq_meta", i), a_dm, tbl[i].hd);
      chk($sformatf("vec%0d deq_data", i), a_dd, tbl[i].dv ? data_of(tbl[i].hd) : 80'h0);
      chk($sformatf("vec%0d peek_valid", i), a_pv, tbl[i].pv);
      chk($sformatf("vec%0d peek_meta", i), a_pm, tbl[i].pk);
      chk($sformatf("vec%0d err_overflow", i), a_ovf, tbl[i].ovf);
    end

    // Steady enqueue+dequeue at occupancy 1: pointers wrap several times.
    @(negedge clk); a_rst = 1;
    @(negedge clk); a_rst = 0; a_ev = 1; a_em = 16'hC000; a_ed = data_of(16'hC000);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      a_ev = 1; a_dr = 1; a_em = 16'hC000 + 16'(i); a_ed = data_of(a_em);
      @(posedge clk);
      #1;
      a_idle();
      #1;
      hd = 16'hC000 + 16'(i);
      chk($sformatf("pair%0d count", i), a_cnt, 1);
      chk($sformatf("pair%0d deq_meta", i), a_dm, hd);
      chk($sformatf("pair%0d deq_data", i), a_dd, data_of(hd));
    end

    // Almost-full threshold on the 5-deep instance, then reset mid-fill.
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      b_ev = 1; b_em = 16'(k); b_ed = data_of(b_em);
      @(posedge clk);
      #1;
      b_ev = 0;
      chk($sformatf("af k=%0d count", k), b_cnt, k);
      chk($sformatf("af k=%0d almost_full", k), b_af, (k >= 4) ? 1 : 0);
    end
    @(negedge clk);
    b_ev = 1; b_rst = 1; b_em = 16'h5; b_ed = data_of(b_em);
    @(posedge clk);
    #1;
    b_ev = 0; b_rst = 0;
    chk("midreset count", b_cnt, 0);
    chk("midreset enq_ready", b_rdy, 1);
    chk("midreset almost_full", b_af, 0);
    chk("midreset deq_valid", b_dv, 0);

    // Randomized traffic against the reference model.
    @(negedge clk); a_rst = 1;
    @(posedge clk);
    mq.delete(); m_ovf = 0;
    for (int c = 0; c < 600; c++) begin
      bit e_rdy, e_dv, fa;
      ent_t e, h;
      @(negedge clk);
      a_rst = ($urandom_range(149) == 0);
      a_ev  = ($urandom_range(3) != 0);
      a_dr  = ($urandom_range(1) == 1);
      a_fl  = ($urandom_range(29) == 0);
      a_fkh = ($urandom_range(19) == 0);
      a_em  = 16'($urandom);
      a_ed  = data_of(a_em);
      #1;
      fa    = a_fl || a_fkh;
      e_rdy = (mq.size() < 3) && !fa;
      e_dv  = (mq.size() > 0) && !fa;
      chk("rnd count", a_cnt, mq.size());
      chk("rnd enq_ready", a_rdy, e_rdy);
      chk("rnd deq_valid", a_dv, e_dv);
      chk("rnd deq_meta", a_dm, e_dv ? mq[0].m : 16'h0);
      chk("rnd deq_data", a_dd, e_dv ? mq[0].d : 80'h0);
      chk("rnd peek_valid", a_pv, mq.size() >= 2);
      chk("rnd peek_meta", a_pm, (mq.size() >= 2) ? mq[1].m : 16'h0);
      chk("rnd almost_full", a_af, mq.size() >= 2);
      chk("rnd err_overflow", a_ovf, m_ovf);
      e.m = a_em; e.d = a_ed;
      @(posedge clk);
      if (a_rst) begin
        mq.delete(); m_ovf = 0;
      end else if (a_fl) begin
        mq.delete();
      end else if (a_fkh) begin
        if (mq.size() > 0) begin
          h = mq[0]; mq.delete(); mq.push_back(h);
        end
      end else begin
        if (a_ev && !e_rdy) m_ovf = 1;
        if (e_dv && a_dr) void'(mq.pop_front());
        if (a_ev && e_rdy) mq.push_back(e);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_instruction_fifo.md
# fpu_instruction_fifo

Parametrised instruction/operand FIFO between the FPU decoder and the numeric execution unit (NEU). It generalises the fixed three-entry control-unit queue with configurable depth and data width and a valid/ready handshake on both sides. It also adds a head+1 lookahead port for operand prefetch, an almost-full threshold, a partial flush that preserves the executing head, and a sticky overflow flag.

## Interface
- DEPTH, 3: number of entries; legal range 2..16; need not be a power of two.
- DATA_W, 80: operand data width.
- META_W, 16: packed descriptor width (opcode 8, stack index 3, has_mem 1, op size 2, is_int 1, is_bcd 1).
- AF_LEVEL, DEPTH-1: almost_full asserts when count >= AF_LEVEL.
- CNT_W, $clog2(DEPTH+1): derived; not overridden.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- enq_valid  in  1  producer has an entry.
- enq_meta  in  META_W  descriptor.
- enq_data  in  DATA_W  operand.
- enq_ready  out  1  FIFO accepts this cycle.
- deq_valid  out  1  head entry present.
- deq_ready  in  1  NEU consumes head.
- deq_meta / deq_data  out  META_W / DATA_W  head entry; zero when deq_valid=0.
- peek_valid  out  1  entry at head+1 present (count>=2).
- peek_meta  out  META_W  descriptor at head+1; zero when peek_valid=0.
- flush  in  1  discard all entries (FINIT, FLDCW, exception).
- flush_keep_head  in  1  discard all entries except the head.
- count  out  CNT_W  occupancy, 0..DEPTH.
- almost_full  out  1  count >= AF_LEVEL.
- err_overflow  out  1  sticky: enq_valid=1 while enq_ready=0 and no flush is active.

## Operation
- Circular buffer of DEPTH entries, with read pointer rd, write pointer wr and registered count. Pointers wrap explicitly: the next pointer after DEPTH-1 is 0.
- enq_ready = (count < DEPTH) && !flush && !flush_keep_head. There is no pass-through when full: a simultaneous dequeue does not open a slot in the same cycle.
- deq_valid = (count != 0) && !flush && !flush_keep_head.
- Enqueue handshake (enq_valid & enq_ready): write the entry at wr, then advance wr.
- Dequeue handshake (deq_valid & deq_ready): advance rd.
- Count: +1 on enqueue only, -1 on dequeue only, unchanged when both occur or neither occurs.
- flush: rd=wr=0 and count=0. Storage contents are not cleared. flush takes priority over flush_keep_head.
- flush_keep_head with count>0: rd unchanged, wr=next(rd), count=1.
- flush_keep_head with count=0: no state change.
- No handshake completes in a flush cycle, because both enq_ready and deq_valid are low.
- err_overflow is set on any rejected enq_valid outside a flush cycle. It is cleared only by reset; flush does not clear it.
- Head and peek outputs are combinational reads of storage, gated to zero when not valid.

## Timing
- Reset values: count=0, rd=wr=0, enq_ready=1, deq_valid=0, peek_valid=0, deq_meta/deq_data/peek_meta=0, almost_full=0 (unless AF_LEVEL=0), err_overflow=0. Storage is zeroed.
- Enqueue-to-head latency is 1 cycle: an entry accepted at edge N is visible on deq_* after edge N. There is no empty bypass.
- count, almost_full and peek_valid update on the same edge as the handshake.
- Reset asserted mid-stream overrides flush and all handshakes in that cycle.
- Full with enq_valid and deq_ready both high: the dequeue completes, the enqueue is rejected and err_overflow is set. Count becomes DEPTH-1 and enq_ready is high in the following cycle.
- Wrap: with DEPTH=3, seven back-to-back enqueue/dequeue pairs return pointer sequences 0,1,2,0,...

## Structure
- Shared package fpu_queue_pkg holds:
  - descriptor field offsets and widths (OPC_LSB, IDX_LSB, ...) and META_W;
  - default DEPTH and DATA_W;
  - a function that packs and unpacks the descriptor, reused by the decoder and the NEU.
- One sub-module, fpu_queue_ptr: a modulo-DEPTH pointer register with increment and load inputs, instantiated twice (rd, wr).

## Test plan
- Fill/drain, DEPTH=3: enqueue meta 0x11, 0x22, 0x33 on consecutive cycles, then try 0x44. Required: enq_ready=0 after the third; err_overflow=1; head order 0x11, 0x22, 0x33; count 3→0; deq_valid=0 at the end.
- Peek: enqueue 0xA1, 0xB2. Required: deq_meta=0xA1, peek_meta=0xB2, peek_valid=1. After one dequeue: peek_valid=0, peek_meta=0.
- Simultaneous enqueue and dequeue at count=1 for 10 cycles. Required: count stays 1, data is in order, and pointers wrap past 2 with no loss.
- flush_keep_head at count=3, head 0x11. Required: next cycle count=1 and deq_meta=0x11. A new enqueue of 0x55 appears at peek the cycle after it is accepted.
- flush asserted together with enq_valid and deq_ready at count=2. Required: no handshake completes, count=0, deq_valid=0, err_overflow unchanged.
- DEPTH=5, AF_LEVEL=4: almost_full rises exactly on the edge where count reaches 4. Reset mid-fill returns count=0 and enq_ready=1 on the next edge.
